alarm_ringer: RTL and testbench

Alarm-side consumer of the settable alarm HH:MM registers: compares the stored alarm time against the running 24-hour clock and drives the buzzer. Provides auto-timeout, limited snooze and stop. It sits between the alarm-setting counters, the main time counters and the board buzzer/LED pins. It is the reader of the values the alarm-set counters write.

---
 rtl/alarm_ringer_pkg.sv | 24 ++
 rtl/alarm_tone_gen.sv | 36 +++
 rtl/alarm_ringer.sv | 137 +++++++++++++
 tb/tb_alarm_ringer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ringer_pkg.sv
// rtl/alarm_ringer_pkg.sv - shared state encodings and BCD time layout for the alarm ringer
package alarm_ringer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RING   = 2'd1;
  localparam logic [1:0] ST_SNOOZE = 2'd2;

  localparam int HR10_W  = 2;
  localparam int HR1_W   = 4;
  localparam int MIN10_W = 3;
  localparam int MIN1_W  = 4;

  typedef struct packed {
    logic [HR10_W-1:0]  hr_10;
    logic [HR1_W-1:0]   hr_1;
    logic [MIN10_W-1:0] min_10;
    logic [MIN1_W-1:0]  min_1;
  } hhmm_t;

  function automatic logic hhmm_match(input hhmm_t a, input hhmm_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/alarm_tone_gen.sv
// rtl/alarm_tone_gen.sv - square-wave phase generator for the buzzer, idle-high outside RUN
module alarm_tone_gen #(
  parameter int TONE_HALF = 25000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RUN,
  input  logic RESTART,
  output logic TONE
);

  localparam int CW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TONE_HALF - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [CW-1:0] r_tone_cnt;
  logic          r_tone_ph;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tone_cnt <= '0;
      r_tone_ph  <= 1'b1;
    end else if (RESTART || !RUN) begin
      r_tone_cnt <= '0;
      r_tone_ph  <= 1'b1;
    end else if (r_tone_cnt == C_LAST) begin
      r_tone_cnt <= '0;
      r_tone_ph  <= ~r_tone_ph;
    end else begin
      r_tone_cnt <= r_tone_cnt + C_ONE;
    end
  end

  assign TONE = r_tone_ph;

endmodule

// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm comparator, ring/snooze FSM with auto-timeout and buzzer drive
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int TONE_HALF  = 25000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                SEC_TICK,
  input  logic                ALARM_EN,
  input  logic                STOP_BTN,
  input  logic                SNOOZE_BTN,
  input  logic [HR10_W-1:0]   AL_HR_10,
  input  logic [HR1_W-1:0]    AL_HR_1,
  input  logic [MIN10_W-1:0]  AL_MIN_10,
  input  logic [MIN1_W-1:0]   AL_MIN_1,
  input  logic [HR10_W-1:0]   TM_HR_10,
  input  logic [HR1_W-1:0]    TM_HR_1,
  input  logic [MIN10_W-1:0]  TM_MIN_10,
  input  logic [MIN1_W-1:0]   TM_MIN_1,
  output logic                BUZZ,
  output logic                RINGING,
  output logic                SNOOZED
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  localparam int UW = $clog2(MAX_SNOOZE + 1);

  localparam logic [RW-1:0] C_RING_LOAD = RW'(RING_SEC);
  localparam logic [RW-1:0] C_RING_ONE  = RW'(1);
  localparam logic [SW-1:0] C_SNZ_LOAD  = SW'(SNOOZE_SEC);
  localparam logic [SW-1:0] C_SNZ_ONE   = SW'(1);
  localparam logic [UW-1:0] C_USED_MAX  = UW'(MAX_SNOOZE);
  localparam logic [UW-1:0] C_USED_ONE  = UW'(1);

  logic [1:0]    r_state, w_state_nxt;
  logic          r_match_q;
  logic [RW-1:0] r_ring_cnt, w_ring_cnt_nxt;
  logic [SW-1:0] r_snz_cnt, w_snz_cnt_nxt;
  logic [UW-1:0] r_snz_used, w_snz_used_nxt;
  logic          r_ringing, r_snoozed, r_buzz;
  logic          w_match, w_trigger, w_tone, w_tone_restart;

  assign w_match   = hhmm_match({AL_HR_10, AL_HR_1, AL_MIN_10, AL_MIN_1},
                                {TM_HR_10, TM_HR_1, TM_MIN_10, TM_MIN_1});
  assign w_trigger = w_match & ~r_match_q & ALARM_EN;

  // Buttons outrank the tick: a press in the same cycle swallows that second.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_snz_used_nxt = r_snz_used;
    if (!ALARM_EN) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            w_state_nxt    = ST_RING;
            w_ring_cnt_nxt = C_RING_LOAD;
            w_snz_used_nxt = '0;
          end
        end
        ST_RING: begin
          if (STOP_BTN) begin
            w_state_nxt = ST_IDLE;
          end else if (SNOOZE_BTN) begin
            if (r_snz_used < C_USED_MAX) begin
              w_state_nxt    = ST_SNOOZE;
              w_snz_cnt_nxt  = C_SNZ_LOAD;
              w_snz_used_nxt = r_snz_used + C_USED_ONE;
            end
          end else if (SEC_TICK) begin
            if (r_ring_cnt <= C_RING_ONE) w_state_nxt = ST_IDLE;
            if (r_ring_cnt != '0) w_ring_cnt_nxt = r_ring_cnt - C_RING_ONE;
          end
        end
        ST_SNOOZE: begin
          if (STOP_BTN) begin
            w_state_nxt = ST_IDLE;
          end else if (!SNOOZE_BTN && SEC_TICK) begin
            if (r_snz_cnt != '0) w_snz_cnt_nxt = r_snz_cnt - C_SNZ_ONE;
            if (r_snz_cnt <= C_SNZ_ONE) begin
              w_state_nxt    = ST_RING;
              w_ring_cnt_nxt = C_RING_LOAD;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_tone_restart = (w_state_nxt == ST_RING) && (r_state != ST_RING);

  alarm_tone_gen #(
    .TONE_HALF(TONE_HALF)
  ) u_tone (
    .CLK     (CLK),
    .RESET   (RESET),
    .RUN     (r_state == ST_RING),
    .RESTART (w_tone_restart),
    .TONE    (w_tone)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_match_q  <= 1'b0;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
      r_snz_used <= '0;
      r_ringing  <= 1'b0;
      r_snoozed  <= 1'b0;
      r_buzz     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_match_q  <= w_match;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_snz_used <= w_snz_used_nxt;
      r_ringing  <= (r_state == ST_RING);
      r_snoozed  <= (r_state == ST_SNOOZE);
      r_buzz     <= (r_state == ST_RING) & w_tone;
    end
  end

  assign RINGING = r_ringing;
  assign SNOOZED = r_snoozed;
  assign BUZZ    = r_buzz;

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed and randomized checks of alarm_ringer against a behavioural model
module tb_alarm_ringer;

  localparam int RING_SEC   = 4;
  localparam int SNOOZE_SEC = 3;
  localparam int MAX_SNOOZE = 2;
  localparam int TONE_HALF  = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       SEC_TICK = 1'b0;
  logic       ALARM_EN = 1'b1;
  logic       STOP_BTN = 1'b0;
  logic       SNOOZE_BTN = 1'b0;
  logic [1:0] AL_HR_10 = '0;
  logic [3:0] AL_HR_1 = '0;
  logic [2:0] AL_MIN_10 = '0;
  logic [3:0] AL_MIN_1 = '0;
  logic [1:0] TM_HR_10 = '0;
  logic [3:0] TM_HR_1 = '0;
  logic [2:0] TM_MIN_10 = '0;
  logic [3:0] TM_MIN_1 = '0;
  logic       BUZZ, RINGING, SNOOZED;

  int n_pass = 0;
  int n_total = 0;

  // Model: mode 0 = silent, 1 = ringing, 2 = snoozing
  int m_mode, m_secs, m_snz, m_age;
  bit m_prev_match;
  bit e_ring, e_snz, e_buzz;

  alarm_ringer #(
    .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC),
    .MAX_SNOOZE(MAX_SNOOZE), .TONE_HALF(TONE_HALF)
  ) dut (
    .CLK(CLK), .RESET(RESET), .SEC_TICK(SEC_TICK), .ALARM_EN(ALARM_EN),
    .STOP_BTN(STOP_BTN), .SNOOZE_BTN(SNOOZE_BTN),
    .AL_HR_10(AL_HR_10), .AL_HR_1(AL_HR_1), .AL_MIN_10(AL_MIN_10), .AL_MIN_1(AL_MIN_1),
    .TM_HR_10(TM_HR_10), .TM_HR_1(TM_HR_1), .TM_MIN_10(TM_MIN_10), .TM_MIN_1(TM_MIN_1),
    .BUZZ(BUZZ), .RINGING(RINGING), .SNOOZED(SNOOZED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  function automatic int alarm_minute();
    return (int'(AL_HR_10) * 10 + int'(AL_HR_1)) * 60 + int'(AL_MIN_10) * 10 + int'(AL_MIN_1);
  endfunction

  function automatic int time_minute();
    return (int'(TM_HR_10) * 10 + int'(TM_HR_1)) * 60 + int'(TM_MIN_10) * 10 + int'(TM_MIN_1);
  endfunction

  task automatic set_alarm(input int h, input int m);
    AL_HR_10 = 2'(h / 10); AL_HR_1 = 4'(h % 10);
    AL_MIN_10 = 3'(m / 10); AL_MIN_1 = 4'(m % 10);
  endtask

  task automatic set_time(input int h, input int m);
    TM_HR_10 = 2'(h / 10); TM_HR_1 = 4'(h % 10);
    TM_MIN_10 = 3'(m / 10); TM_MIN_1 = 4'(m % 10);
  endtask

  task automatic model_reset();
    m_mode = 0; m_secs = 0; m_snz = 0; m_age = 0;
    m_prev_match = 1'b0;
    e_ring = 1'b0; e_snz = 1'b0; e_buzz = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit match, trig;
    match  = (alarm_minute() == time_minute());
    e_ring = (m_mode == 1);
    e_snz  = (m_mode == 2);
    e_buzz = e_ring && (((m_age / TONE_HALF) % 2) == 0);
    if (m_mode == 1) m_age++;
    trig = match && !m_prev_match && ALARM_EN;
    m_prev_match = match;
    if (!ALARM_EN) m_mode = 0;
    else if (m_mode == 0) begin
      if (trig) begin m_mode = 1; m_secs = RING_SEC; m_snz = 0; m_age = 0; end
    end else if (STOP_BTN) m_mode = 0;
    else if (SNOOZE_BTN) begin
      if (m_mode == 1 && m_snz < MAX_SNOOZE) begin
        m_mode = 2; m_secs = SNOOZE_SEC; m_snz++;
      end
    end else if (SEC_TICK) begin
      m_secs--;
      if (m_secs == 0) begin
        if (m_mode == 1) m_mode = 0;
        else begin m_mode = 1; m_secs = RING_SEC; m_age = 0; end
      end
    end
  endtask

  task automatic compare();
    check("RINGING", RINGING, e_ring);
    check("SNOOZED", SNOOZED, e_snz);
    check("BUZZ", BUZZ, e_buzz);
  endtask

  // Called at a falling edge; applies buttons, crosses one rising edge, then compares.
  task automatic step(input bit stop, input bit snz, input bit tick);
    STOP_BTN = stop; SNOOZE_BTN = snz; SEC_TICK = tick;
    model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    model_reset();
    #1;
    check("async_rst_ringing", RINGING, 1'b0);
    check("async_rst_snoozed", SNOOZED, 1'b0);
    check("async_rst_buzz", BUZZ, 1'b0);
    @(negedge CLK);
    compare();
    STOP_BTN = 1'b0; SNOOZE_BTN = 1'b0; SEC_TICK = 1'b0;
    RESET = 1'b1;
  endtask

  task automatic retrigger();
    set_time(7, 31); step(0, 0, 0);
    set_time(7, 30); step(0, 0, 0);
    step(0, 0, 0);
  endtask

  logic [7:0] buzz_pat;

  initial begin
    model_reset();
    set_alarm(7, 30);
    set_time(7, 29);
    repeat (2) @(negedge CLK);
    check("reset_ringing", RINGING, 1'b0);
    check("reset_snoozed", SNOOZED, 1'b0);
    check("reset_buzz", BUZZ, 1'b0);
    RESET = 1'b1;
    step(0, 0, 0); step(0, 0, 0);

    // Trigger and tone pattern
    set_time(7, 30); step(0, 0, 0);
    check("trig_not_yet", RINGING, 1'b0);
    step(0, 0, 0);
    check("trig_ringing", RINGING, 1'b1);
    buzz_pat = 8'b11110000;
    check("buzz_0", BUZZ, buzz_pat[7]);
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0);
      check("buzz_pattern", BUZZ, buzz_pat[7-i]);
    end

    // Timeout after four ticks, no retrigger while the minute holds
    for (int i = 0; i < 4; i++) begin step(0, 0, 1); step(0, 0, 0); end
    check("timeout_off", RINGING, 1'b0);
    repeat (5) step(0, 0, 0);
    check("no_retrigger", RINGING, 1'b0);

    // Snooze twice, third press ignored, then stop+snooze together
    retrigger();
    check("snz_ring", RINGING, 1'b1);
    step(0, 1, 0); step(0, 0, 0);
    check("snz_1_on", SNOOZED, 1'b1);
    check("snz_1_quiet", BUZZ, 1'b0);
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    check("snz_1_back", RINGING, 1'b1);
    step(0, 1, 0); step(0, 0, 0);
    check("snz_2_on", SNOOZED, 1'b1);
    repeat (3) step(0, 0, 1);
    step(0, 0, 0);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    check("snz_3_ring", RINGING, 1'b1);
    check("snz_3_nosnz", SNOOZED, 1'b0);
    step(1, 1, 0); step(0, 0, 0);
    check("stop_and_snooze", RINGING, 1'b0);

    // Stop while snoozed; disable while ringing
    retrigger();
    step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    check("stop_in_snz", SNOOZED, 1'b0);
    retrigger();
    ALARM_EN = 1'b0; step(0, 0, 0); step(0, 0, 0);
    check("en_drop", RINGING, 1'b0);
    ALARM_EN = 1'b1; step(0, 0, 0);

    // Reset mid-ring, retrigger on the first edge after release
    retrigger();
    do_reset();
    step(0, 0, 0);
    check("post_rst_edge1", RINGING, 1'b0);
    step(0, 0, 0);
    check("post_rst_edge2", RINGING, 1'b1);
    step(1, 0, 0); step(0, 0, 0);

    // Midnight boundary and disabled match
    set_alarm(23, 59);
    set_time(23, 58); step(0, 0, 0);
    set_time(23, 59); step(0, 0, 0); step(0, 0, 0);
    check("b2359_ring", RINGING, 1'b1);
    step(1, 0, 0);
    set_time(0, 0); repeat (4) step(0, 0, 0);
    check("b0000_quiet", RINGING, 1'b0);
    ALARM_EN = 1'b0;
    set_time(23, 58); step(0, 0, 0);
    set_time(23, 59); step(0, 0, 0); step(0, 0, 0);
    ALARM_EN = 1'b1; repeat (3) step(0, 0, 0);
    check("late_enable", RINGING, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int pick, ah, am;
      if ($urandom_range(0, 199) == 0) begin
        pick = $urandom_range(0, 2);
        if (pick == 0) set_alarm(7, 30);
        else if (pick == 1) set_alarm(23, 59);
        else set_alarm(12, 5);
      end
      if ($urandom_range(0, 19) == 0) begin
        ah = alarm_minute() / 60; am = alarm_minute() % 60;
        if ($urandom_range(0, 1) == 0) set_time(ah, am);
        else set_time(6, $urandom_range(0, 59));
      end
      if ($urandom_range(0, 149) == 0) ALARM_EN = ~ALARM_EN;
      if ($urandom_range(0, 799) == 0) do_reset();
      else step($urandom_range(0, 59) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
